// File: rtl/keccak_rc_generator.sv
// Keccak iota round-constant generator from an 8-bit LFSR; KECCAK_RC_ROUND_SKIP_EN adds a reduced-round start.
// First group one cycle after StartxSI; holds while NextxSI is low and advances one group per accepted NextxSI.
module keccak_rc_generator #(
    parameter int W      = 64,
    parameter int UNROLL = 1
) (
    input  logic                ClkxCI,
    input  logic                RstxRBI,
    input  logic                StartxSI,
    input  logic                NextxSI,
`ifdef KECCAK_RC_ROUND_SKIP_EN
    input  logic [4:0]          NumRoundsxDI,
`endif
    output logic [UNROLL*W-1:0] RCxDO,
    output logic [4:0]          RoundxDO,
    output logic                ValidxSO,
    output logic                LastxSO,
    output logic                DonexSO
);
    localparam int         L      = $clog2(W);
    localparam int         ROUNDS = 12 + 2 * L;
    localparam logic [7:0] SEED   = 8'h01;

`ifdef KECCAK_RC_ROUND_SKIP_EN
    typedef enum logic [1:0] {IDLE, SEEK, RUN} state_t;
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif

    state_t              state_q, state_d;
    logic [4:0]          round_q, round_d;
    logic [7:0]          lfsr_q, lfsr_d, lfsr_grp_nxt;
    logic                done_q, done_d;
    logic [UNROLL*W-1:0] rc_lanes;
    logic                last;

    function automatic logic [7:0] lfsr_step(input logic [7:0] r);
        logic [7:0] n;
        n    = {r[6:0], r[7]};
        n[4] = r[3] ^ r[7];
        n[5] = r[4] ^ r[7];
        n[6] = r[5] ^ r[7];
        return n;
    endfunction

    // lfsr_q sits at rc(7*RoundxDO); every lane consumes exactly seven LFSR steps
    always_comb begin
        logic [7:0] r;
        r        = lfsr_q;
        rc_lanes = '0;
        for (int k = 0; k < UNROLL; k++) begin
            for (int j = 0; j <= L; j++) begin
                rc_lanes[k*W + (2**j) - 1] = r[0];
                r = lfsr_step(r);
            end
            for (int j = L + 1; j < 7; j++) begin
                r = lfsr_step(r);
            end
        end
        lfsr_grp_nxt = r;
    end

`ifdef KECCAK_RC_ROUND_SKIP_EN
    logic [4:0] start_round;
    logic [4:0] seek_target_q;
    logic [7:0] lfsr_one_nxt;

    assign start_round = 5'(ROUNDS) - NumRoundsxDI;

    // SEEK walks one round per cycle regardless of UNROLL
    always_comb begin
        lfsr_one_nxt = lfsr_q;
        for (int j = 0; j < 7; j++) begin
            lfsr_one_nxt = lfsr_step(lfsr_one_nxt);
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            seek_target_q <= '0;
        end else if (StartxSI) begin
            seek_target_q <= start_round;
        end
    end
`endif

    assign last = (state_q == RUN) && (({1'b0, round_q} + 6'(UNROLL)) == 6'(ROUNDS));

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        lfsr_d  = lfsr_q;
        done_d  = 1'b0;
        if (StartxSI) begin
            round_d = '0;
            lfsr_d  = SEED;
`ifdef KECCAK_RC_ROUND_SKIP_EN
            state_d = (start_round == 5'd0) ? RUN : SEEK;
`else
            state_d = RUN;
`endif
        end else begin
            case (state_q)
                RUN: begin
                    if (NextxSI) begin
                        if (last) begin
                            state_d = IDLE;
                            round_d = '0;
                            lfsr_d  = SEED;
                            done_d  = 1'b1;
                        end else begin
                            round_d = round_q + 5'(UNROLL);
                            lfsr_d  = lfsr_grp_nxt;
                        end
                    end
                end
`ifdef KECCAK_RC_ROUND_SKIP_EN
                SEEK: begin
                    round_d = round_q + 5'd1;
                    lfsr_d  = lfsr_one_nxt;
                    if ((round_q + 5'd1) == seek_target_q) begin
                        state_d = RUN;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            state_q <= IDLE;
            round_q <= '0;
            lfsr_q  <= SEED;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            lfsr_q  <= lfsr_d;
            done_q  <= done_d;
        end
    end

    assign ValidxSO = (state_q == RUN);
    assign RCxDO    = ValidxSO ? rc_lanes : '0;
    assign RoundxDO = round_q;
    assign LastxSO  = last;
    assign DonexSO  = done_q;

endmodule
